snax_hwpe_periph_regfile: RTL and testbench

- Target (slave) end of the HWPE peripheral control interface. It receives 32-bit register reads and writes that the Snitch-side control bridge issues on the periph bus.
- Holds a staging bank of job configuration registers and a trigger/status register set, and runs a job-control FSM.
- On trigger, the FSM copies staging into a stable shadow bank and pulses start to the accelerator datapath. It then waits for done and reports completion through status and an event pulse.
- Sits inside the SNAX shell, between the control bridge and the accelerator core.

---
 rtl/snax_hwpe_periph_regfile.sv | 190 +++++++++++++++++++
 tb/tb_snax_hwpe_periph_regfile.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snax_hwpe_periph_regfile.sv
// rtl/snax_hwpe_periph_regfile.sv - HWPE periph-bus register file with staging/shadow config and job-control FSM
module snax_hwpe_periph_regfile #(
  parameter int unsigned NumCfgRegs  = 8,
  parameter int unsigned IdWidth     = 5,
  parameter int unsigned JobCntWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     periph_req_i,
  output logic                     periph_gnt_o,
  input  logic [31:0]              periph_add_i,
  input  logic                     periph_wen_i,
  input  logic [3:0]               periph_be_i,
  input  logic [31:0]              periph_data_i,
  input  logic [IdWidth-1:0]       periph_id_i,
  output logic                     periph_r_valid_o,
  output logic [31:0]              periph_r_data_o,
  output logic [IdWidth-1:0]       periph_r_id_o,
  output logic [NumCfgRegs*32-1:0] cfg_o,
  output logic                     start_o,
  output logic                     clear_o,
  input  logic                     done_i,
  output logic                     busy_o,
  output logic                     evt_o
);

  localparam int unsigned IdxTrigger = 0;
  localparam int unsigned IdxStatus  = 1;
  localparam int unsigned IdxClear   = 2;
  localparam int unsigned CfgBase    = 3;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Start = 2'd1,
    Busy  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            stage_q [NumCfgRegs];
  logic [31:0]            stage_d [NumCfgRegs];
  logic [31:0]            cfg_q   [NumCfgRegs];
  logic                   pending_q, pending_d;
  logic [JobCntWidth-1:0] jobs_q, jobs_d;
  logic                   evt_q, evt_d;
  logic                   clear_q;
  logic                   load_cfg;
  logic                   r_valid_q;
  logic [31:0]            r_data_q;
  logic [IdWidth-1:0]     r_id_q;

  logic [31:0] idx;
  logic        wr_en, rd_en;
  logic        trig, clr;
  logic [31:0] status;
  logic [31:0] rdata;
  logic        unused_add;

  // Only the word index within a 256-byte window is decoded.
  assign idx        = {26'd0, periph_add_i[7:2]};
  assign unused_add = ^{periph_add_i[31:8], periph_add_i[1:0]};

  assign periph_gnt_o = periph_req_i;
  assign wr_en        = periph_req_i & ~periph_wen_i;
  assign rd_en        = periph_req_i & periph_wen_i;
  assign trig         = wr_en & (idx == IdxTrigger) & periph_be_i[0];
  assign clr          = wr_en & (idx == IdxClear) & periph_be_i[0];

  always_comb begin
    status                     = '0;
    status[0]                  = (state_q != Idle);
    status[1]                  = pending_q;
    status[8 +: JobCntWidth]   = jobs_q;
  end

  always_comb begin
    rdata = '0;
    if (idx == IdxStatus) begin
      rdata = status;
    end
    for (int unsigned k = 0; k < NumCfgRegs; k++) begin
      if (idx == CfgBase + k) begin
        rdata = stage_q[k];
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NumCfgRegs; k++) begin
      stage_d[k] = stage_q[k];
      if (wr_en && (idx == CfgBase + k)) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (periph_be_i[b]) begin
            stage_d[k][8*b +: 8] = periph_data_i[8*b +: 8];
          end
        end
      end
      if (clr) begin
        stage_d[k] = '0;
      end
    end
  end

  // Shadow is loaded on entry to Start so cfg_o is already stable while start_o is high.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    jobs_d    = jobs_q;
    evt_d     = 1'b0;
    load_cfg  = 1'b0;
    unique case (state_q)
      Idle: begin
        if (trig || pending_q) begin
          state_d  = Start;
          load_cfg = 1'b1;
        end
      end
      Start: begin
        state_d   = Busy;
        pending_d = trig;
      end
      Busy: begin
        if (trig) begin
          pending_d = 1'b1;
        end
        if (done_i) begin
          state_d = Idle;
          evt_d   = 1'b1;
          jobs_d  = jobs_q + JobCntWidth'(1);
        end
      end
      default: state_d = Idle;
    endcase
    if (clr) begin
      state_d   = Idle;
      pending_d = 1'b0;
      jobs_d    = '0;
      evt_d     = 1'b0;
      load_cfg  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      pending_q <= 1'b0;
      jobs_q    <= '0;
      evt_q     <= 1'b0;
      clear_q   <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_id_q    <= '0;
      for (int unsigned k = 0; k < NumCfgRegs; k++) begin
        stage_q[k] <= '0;
        cfg_q[k]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      jobs_q    <= jobs_d;
      evt_q     <= evt_d;
      clear_q   <= clr;
      r_valid_q <= rd_en;
      if (rd_en) begin
        r_data_q <= rdata;
        r_id_q   <= periph_id_i;
      end
      for (int unsigned k = 0; k < NumCfgRegs; k++) begin
        stage_q[k] <= stage_d[k];
        if (clr) begin
          cfg_q[k] <= '0;
        end else if (load_cfg) begin
          cfg_q[k] <= stage_d[k];
        end
      end
    end
  end

  for (genvar g = 0; g < NumCfgRegs; g++) begin : gen_cfg_out
    assign cfg_o[32*g +: 32] = cfg_q[g];
  end

  assign periph_r_valid_o = r_valid_q;
  assign periph_r_data_o  = r_data_q;
  assign periph_r_id_o    = r_id_q;
  assign start_o          = (state_q == Start);
  assign busy_o           = (state_q != Idle);
  assign clear_o          = clear_q;
  assign evt_o            = evt_q;

endmodule

// File: tb/tb_snax_hwpe_periph_regfile.sv
// tb/tb_snax_hwpe_periph_regfile.sv - randomized self-checking bench against a cycle-level job model
module tb_snax_hwpe_periph_regfile;

  localparam int NCFG = 8;
  localparam int IDW  = 5;
  localparam int JCW  = 8;
  localparam int CW   = NCFG * 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req, gnt, wen, done;
  logic [31:0]     add, wdata, r_data;
  logic [3:0]      be;
  logic [IDW-1:0]  id, r_id;
  logic            r_valid, start, clear, busy, evt;
  logic [CW-1:0]   cfg;

  always #5 clk = ~clk;

  snax_hwpe_periph_regfile #(
    .NumCfgRegs (NCFG),
    .IdWidth    (IDW),
    .JobCntWidth(JCW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .periph_req_i    (req),
    .periph_gnt_o    (gnt),
    .periph_add_i    (add),
    .periph_wen_i    (wen),
    .periph_be_i     (be),
    .periph_data_i   (wdata),
    .periph_id_i     (id),
    .periph_r_valid_o(r_valid),
    .periph_r_data_o (r_data),
    .periph_r_id_o   (r_id),
    .cfg_o           (cfg),
    .start_o         (start),
    .clear_o         (clear),
    .done_i          (done),
    .busy_o          (busy),
    .evt_o           (evt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: job phase (no job / just launched / running), queue flag, counter, banks.
  localparam int PH_NONE = 0, PH_LAUNCH = 1, PH_RUN = 2;
  int          m_phase;
  bit          m_pend;
  int          m_cnt;
  logic [31:0] m_stg [NCFG];
  logic [31:0] m_cfg [NCFG];
  bit          e_rv, e_evt, e_clr;
  logic [31:0] e_rd;
  logic [IDW-1:0] e_rid;

  int n_start = 0, n_evt = 0;
  logic [31:0] last_rd;

  function automatic logic [CW-1:0] m_pack();
    logic [CW-1:0] p;
    for (int k = 0; k < NCFG; k++) p[32*k +: 32] = m_cfg[k];
    return p;
  endfunction

  task automatic m_reset();
    m_phase = PH_NONE; m_pend = 0; m_cnt = 0;
    for (int k = 0; k < NCFG; k++) begin m_stg[k] = 0; m_cfg[k] = 0; end
    e_rv = 0; e_evt = 0; e_clr = 0; e_rd = 0; e_rid = 0;
  endtask

  function automatic logic [31:0] m_read(input int widx);
    if (widx == 1) return (32'(m_cnt) << 8) | (32'(m_pend) << 1) | 32'(m_phase != PH_NONE);
    if (widx >= 3 && widx < 3 + NCFG) return m_stg[widx-3];
    return 32'd0;
  endfunction

  task automatic m_step(input bit rq, input bit wn, input logic [31:0] ad, input logic [3:0] b,
                        input logic [31:0] d, input logic [IDW-1:0] i, input bit dn);
    int widx = int'(ad[7:2]);
    bit wr = rq && !wn;
    bit trg = wr && widx == 0 && b[0];
    bit clrw = wr && widx == 2 && b[0];
    e_rv = rq && wn;
    if (e_rv) begin e_rd = m_read(widx); e_rid = i; end
    e_evt = 0;
    e_clr = clrw;
    if (clrw) begin
      m_phase = PH_NONE; m_pend = 0; m_cnt = 0;
      for (int k = 0; k < NCFG; k++) begin m_stg[k] = 0; m_cfg[k] = 0; end
    end else begin
      if (wr && widx >= 3 && widx < 3 + NCFG)
        for (int y = 0; y < 4; y++) if (b[y]) m_stg[widx-3][8*y +: 8] = d[8*y +: 8];
      case (m_phase)
        PH_NONE: if (trg || m_pend) begin
          m_phase = PH_LAUNCH;
          for (int k = 0; k < NCFG; k++) m_cfg[k] = m_stg[k];
        end
        PH_LAUNCH: begin m_phase = PH_RUN; m_pend = trg; end
        default: begin
          if (trg) m_pend = 1;
          if (dn) begin m_phase = PH_NONE; e_evt = 1; m_cnt = (m_cnt + 1) % (1 << JCW); end
        end
      endcase
    end
  endtask

  task automatic cyc(input bit rq, input bit wn, input logic [31:0] ad, input logic [3:0] b,
                     input logic [31:0] d, input logic [IDW-1:0] i, input bit dn);
    @(negedge clk);
    req = rq; wen = wn; add = ad; be = b; wdata = d; id = i; done = dn;
    #1;
    check_eq("gnt", CW'(gnt), CW'(rq));
    m_step(rq, wn, ad, b, d, i, dn);
    @(posedge clk);
    #1;
    check_eq("r_valid", CW'(r_valid), CW'(e_rv));
    if (e_rv) begin
      check_eq("r_data", CW'(r_data), CW'(e_rd));
      check_eq("r_id", CW'(r_id), CW'(e_rid));
      last_rd = r_data;
    end
    check_eq("start", CW'(start), CW'(m_phase == PH_LAUNCH));
    check_eq("busy", CW'(busy), CW'(m_phase != PH_NONE));
    check_eq("evt", CW'(evt), CW'(e_evt));
    check_eq("clear", CW'(clear), CW'(e_clr));
    check_eq("cfg", cfg, m_pack());
    if (start) n_start++;
    if (evt) n_evt++;
  endtask

  task automatic idle_c();                     cyc(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic done_c();                     cyc(0, 0, 0, 0, 0, 0, 1); endtask
  task automatic wr_c(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    cyc(1, 0, a, b, d, 0, 0);
  endtask
  task automatic rd_c(input logic [31:0] a, input logic [IDW-1:0] i); cyc(1, 1, a, 4'h0, 0, i, 0); endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rv"}, CW'(r_valid), 0);
    check_eq({tag, "_rd"}, CW'(r_data), 0);
    check_eq({tag, "_rid"}, CW'(r_id), 0);
    check_eq({tag, "_cfg"}, cfg, 0);
    check_eq({tag, "_ctl"}, CW'({start, clear, busy, evt}), 0);
  endtask

  initial begin
    req = 0; wen = 0; add = 0; be = 0; wdata = 0; id = 0; done = 0;
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    rd_c(32'h04, 5'd3);
    check_eq("status_after_reset", CW'(last_rd), 0);
    check_eq("status_rid", CW'(r_id), 3);

    wr_c(32'h0C, 4'hF, 32'hA5A5A5A5);
    wr_c(32'h0C, 4'h1, 32'h000000FF);
    rd_c(32'h0C, 5'd1);
    check_eq("stage_be_merge", CW'(last_rd), CW'(32'hA5A5A5FF));
    check_eq("cfg_before_trig", CW'(cfg[31:0]), 0);

    wr_c(32'h00, 4'hF, 32'h1);
    check_eq("start_pulse", CW'(start), 1);
    check_eq("cfg_at_start", CW'(cfg[31:0]), CW'(32'hA5A5A5FF));
    idle_c(); idle_c();
    check_eq("busy_hold", CW'(busy), 1);
    done_c();
    check_eq("evt_after_done", CW'(evt), 1);
    check_eq("busy_after_done", CW'(busy), 0);
    rd_c(32'h04, 5'd7);
    check_eq("status_one_job", CW'(last_rd), CW'(32'h100));

    wr_c(32'h08, 4'h1, 32'h1);
    wr_c(32'h00, 4'h1, 32'h1);
    idle_c();
    wr_c(32'h00, 4'h1, 32'h1);
    wr_c(32'h00, 4'h1, 32'h1);
    rd_c(32'h04, 5'd2);
    check_eq("pending_bit", CW'(last_rd[1]), 1);
    n_start = 0;
    done_c(); idle_c(); idle_c(); idle_c();
    check_eq("one_queued_start", CW'(n_start), 1);
    done_c(); idle_c(); idle_c();
    check_eq("no_extra_start", CW'(n_start), 1);
    rd_c(32'h04, 5'd4);
    check_eq("jobcnt_two", CW'(last_rd[15:8]), 2);

    wr_c(32'h10, 4'hF, 32'h12345678);
    wr_c(32'h00, 4'h1, 32'h1);
    idle_c();
    wr_c(32'h00, 4'h1, 32'h1);
    n_start = 0; n_evt = 0;
    cyc(1, 0, 32'h08, 4'h1, 32'h1, 0, 1);
    check_eq("clear_pulse", CW'(clear), 1);
    check_eq("clear_busy", CW'(busy), 0);
    check_eq("clear_cfg", cfg, 0);
    idle_c(); done_c(); idle_c();
    check_eq("clear_no_evt_start", CW'(n_start + n_evt), 0);
    rd_c(32'h04, 5'd5);
    check_eq("clear_status", CW'(last_rd), 0);

    wr_c(32'h0C, 4'hF, 32'hDEADBEEF);
    rd_c(32'h80, 5'd9);
    check_eq("oob_read", CW'(last_rd), 0);

    for (int j = 0; j < 256; j++) begin
      wr_c(32'h00, 4'h1, 32'h1);
      idle_c();
      done_c();
      if (j == 254) begin
        rd_c(32'h04, 5'd0);
        check_eq("jobcnt_255", CW'(last_rd[15:8]), 255);
      end
    end
    rd_c(32'h04, 5'd0);
    check_eq("jobcnt_wrap", CW'(last_rd), 0);

    wr_c(32'h00, 4'h1, 32'h1);
    idle_c();
    @(negedge clk);
    req = 0; done = 0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", CW'(busy), 0);
    check_eq("async_rst_cfg", cfg, 0);
    m_reset();
    @(posedge clk); #1;
    check_all_zero("midjob_reset");
    @(negedge clk) rst_n = 1'b1;
    done_c();
    check_eq("rst_no_evt", CW'(evt), 0);

    for (int n = 0; n < 4000; n++) begin
      bit rq = ($urandom_range(0, 9) < 7);
      bit wn = $urandom_range(0, 1);
      int sel = $urandom_range(0, 7);
      int widx;
      logic [31:0] rnd = $urandom;
      case (sel)
        0, 7:    widx = 0;
        1:       widx = 1;
        2:       widx = ($urandom_range(0, 19) == 0) ? 2 : 3;
        6:       widx = $urandom_range(0, 63);
        default: widx = 3 + $urandom_range(0, NCFG - 1);
      endcase
      cyc(rq, wn, {rnd[31:8], 6'(widx), rnd[1:0]}, 4'($urandom), $urandom,
          IDW'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
